hdlc_protocol_monitor: RTL and testbench

HDLC_PROTOCOL_MONITOR -- requirements
Module: hdlc_protocol_monitor

---
 rtl/hdlc_protocol_monitor_if.sv | 32 +++
 rtl/hdlc_protocol_monitor.sv | 127 ++++++++++++
 tb/tb_hdlc_protocol_monitor.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/hdlc_protocol_monitor_if.sv
// Signal bundle between an HDLC Rx/Tx datapath under observation and the
// protocol monitor. The monitor connects through the slave modport.
interface hdlc_protocol_monitor_if #(
  parameter int CNT_W = 16
);
  logic             Rx;
  logic             Rx_FlagDetect;
  logic             Rx_AbortDetect;
  logic             Rx_ValidFrame;
  logic             Rx_AbortSignal;
  logic             Tx;
  logic             Tx_ValidFrame;
  logic [3:0]       Chk_En;
  logic             Clr;
  logic [3:0]       Err_Pulse;
  logic [3:0]       Err_Sticky;
  logic [CNT_W-1:0] Err_Cnt;
  logic [1:0]       First_Err_Id;
  logic             First_Err_Valid;

  modport master (
    output Rx, Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_AbortSignal,
    output Tx, Tx_ValidFrame, Chk_En, Clr,
    input  Err_Pulse, Err_Sticky, Err_Cnt, First_Err_Id, First_Err_Valid
  );

  modport slave (
    input  Rx, Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_AbortSignal,
    input  Tx, Tx_ValidFrame, Chk_En, Clr,
    output Err_Pulse, Err_Sticky, Err_Cnt, First_Err_Id, First_Err_Valid
  );
endinterface

// File: rtl/hdlc_protocol_monitor.sv
// HDLC protocol monitor: watches the serial Rx line for flag/abort patterns
// and checks that the Rx status outputs and Tx idle behaviour follow them.
// Failures are reported as per-check strobes, sticky bits, a saturating
// count and the index of the first recorded failure.
module hdlc_protocol_monitor #(
  parameter int FLAG_LAT  = 2,
  parameter int ABORT_LAT = 2,
  parameter int IDLE_LEN  = 8,
  parameter int CNT_W     = 16
) (
  input logic                  Clk,
  input logic                  Rst,
  hdlc_protocol_monitor_if.slave bus
);

  localparam int IW = $clog2(IDLE_LEN + 1);
  localparam logic [IW-1:0]      IDLE_MAX = IW'(IDLE_LEN);
  localparam logic [CNT_W+2:0]   CNT_MAX  = {3'b000, {CNT_W{1'b1}}};
  localparam logic [7:0]         FLAG_PAT  = 8'b0111_1110;
  localparam logic [7:0]         ABORT_PAT = 8'b0111_1111;

  // Rx window: bit 7 is the oldest sample, bit 0 the newest.
  logic [7:0]           win_q, win_d;
  logic [3:0]           fill_q, fill_d;
  logic [FLAG_LAT-1:0]  fdl_q, fdl_d;
  logic [ABORT_LAT-1:0] adl_q, adl_d;
  logic                 ad_prev_q;
  logic                 as_due_q;
  logic [IW-1:0]        idle_q, idle_d;
  logic                 idle_due_q;
  logic                 flag_match, abort_match, idle_arm, ad_rise;

  logic [3:0]           fail;
  logic [2:0]           n_fail;
  logic [CNT_W+2:0]     sum;
  logic [3:0]           pulse_q;
  logic [3:0]           sticky_q, sticky_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           fid_q, fid_d;
  logic                 fval_q, fval_d;

  // Pattern detection on the window including the current sample, plus
  // the shift of pending expectations toward their due cycle.
  always_comb begin
    win_d       = {win_q[6:0], bus.Rx};
    fill_d      = (fill_q == 4'd8) ? fill_q : fill_q + 4'd1;
    flag_match  = (fill_d == 4'd8) && (win_d == FLAG_PAT);
    abort_match = (fill_d == 4'd8) && (win_d == ABORT_PAT);
    fdl_d       = '0;
    fdl_d[0]    = flag_match;
    for (int i = 1; i < FLAG_LAT; i++) fdl_d[i] = fdl_q[i-1];
    adl_d       = '0;
    adl_d[0]    = abort_match;
    for (int i = 1; i < ABORT_LAT; i++) adl_d[i] = adl_q[i-1];
    idle_arm    = !bus.Tx_ValidFrame && (idle_q == IDLE_MAX);
    if (bus.Tx_ValidFrame)      idle_d = '0;
    else if (idle_q == IDLE_MAX) idle_d = idle_q;
    else                         idle_d = idle_q + IW'(1);
  end

  // Evaluate due expectations and fold failures into the error record.
  // A clear in the same cycle wipes the old record before the new failures land.
  always_comb begin
    ad_rise  = bus.Rx_AbortDetect && !ad_prev_q;
    fail[0]  = fdl_q[FLAG_LAT-1]  && !bus.Rx_FlagDetect  && bus.Chk_En[0];
    fail[1]  = adl_q[ABORT_LAT-1] && !ad_rise            && bus.Chk_En[1];
    fail[2]  = as_due_q           && !bus.Rx_AbortSignal && bus.Chk_En[2];
    fail[3]  = idle_due_q         && !bus.Tx             && bus.Chk_En[3];
    n_fail   = {2'b00, fail[0]} + {2'b00, fail[1]} + {2'b00, fail[2]} + {2'b00, fail[3]};
    sticky_d = (bus.Clr ? 4'b0000 : sticky_q) | fail;
    sum      = {3'b000, (bus.Clr ? {CNT_W{1'b0}} : cnt_q)} + (CNT_W+3)'(n_fail);
    cnt_d    = (sum > CNT_MAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    fid_d    = fid_q;
    fval_d   = fval_q;
    if (bus.Clr) begin
      fid_d  = 2'd0;
      fval_d = 1'b0;
    end
    if ((bus.Clr || !fval_q) && (|fail)) begin
      fval_d = 1'b1;
      if (fail[0])      fid_d = 2'd0;
      else if (fail[1]) fid_d = 2'd1;
      else if (fail[2]) fid_d = 2'd2;
      else              fid_d = 2'd3;
    end
  end

  // State registers; reset also discards every pending expectation.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      win_q      <= '0;
      fill_q     <= '0;
      fdl_q      <= '0;
      adl_q      <= '0;
      ad_prev_q  <= 1'b0;
      as_due_q   <= 1'b0;
      idle_q     <= '0;
      idle_due_q <= 1'b0;
      pulse_q    <= '0;
      sticky_q   <= '0;
      cnt_q      <= '0;
      fid_q      <= '0;
      fval_q     <= 1'b0;
    end else begin
      win_q      <= win_d;
      fill_q     <= fill_d;
      fdl_q      <= fdl_d;
      adl_q      <= adl_d;
      ad_prev_q  <= bus.Rx_AbortDetect;
      as_due_q   <= bus.Rx_AbortDetect && bus.Rx_ValidFrame;
      idle_q     <= idle_d;
      idle_due_q <= idle_arm;
      pulse_q    <= fail;
      sticky_q   <= sticky_d;
      cnt_q      <= cnt_d;
      fid_q      <= fid_d;
      fval_q     <= fval_d;
    end
  end

  assign bus.Err_Pulse       = pulse_q;
  assign bus.Err_Sticky      = sticky_q;
  assign bus.Err_Cnt         = cnt_q;
  assign bus.First_Err_Id    = fid_q;
  assign bus.First_Err_Valid = fval_q;

endmodule

// File: tb/tb_hdlc_protocol_monitor.sv
// Directed bench for hdlc_protocol_monitor: a default-width instance plus a
// CNT_W=2 instance sharing the same stimulus for counter saturation.
module tb_hdlc_protocol_monitor;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  hdlc_protocol_monitor_if #(.CNT_W(16)) b1 ();
  hdlc_protocol_monitor_if #(.CNT_W(2))  b2 ();

  hdlc_protocol_monitor #(.CNT_W(16)) dut1 (.Clk(Clk), .Rst(Rst), .bus(b1));
  hdlc_protocol_monitor #(.CNT_W(2))  dut2 (.Clk(Clk), .Rst(Rst), .bus(b2));

  assign b2.Rx             = b1.Rx;
  assign b2.Rx_FlagDetect  = b1.Rx_FlagDetect;
  assign b2.Rx_AbortDetect = b1.Rx_AbortDetect;
  assign b2.Rx_ValidFrame  = b1.Rx_ValidFrame;
  assign b2.Rx_AbortSignal = b1.Rx_AbortSignal;
  assign b2.Tx             = b1.Tx;
  assign b2.Tx_ValidFrame  = b1.Tx_ValidFrame;
  assign b2.Chk_En         = b1.Chk_En;
  assign b2.Clr            = b1.Clr;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;

  typedef struct {
    logic       ad;
    logic       vf;
    logic       as_n;
    logic       en;
    logic [3:0] exp_pulse;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Advance one cycle; inputs set before the call are sampled at this edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Drive 8 Rx bits oldest first; returns in the cycle after the last bit.
  task automatic send_rx(input logic [7:0] bits);
    for (int i = 7; i >= 0; i--) begin
      b1.Rx = bits[i];
      tick();
    end
    b1.Rx = 1'b0;
  endtask

  initial begin
    vecs[0] = '{ad: 1'b1, vf: 1'b1, as_n: 1'b0, en: 1'b1, exp_pulse: 4'b0100};
    vecs[1] = '{ad: 1'b1, vf: 1'b1, as_n: 1'b1, en: 1'b1, exp_pulse: 4'b0000};
    vecs[2] = '{ad: 1'b1, vf: 1'b0, as_n: 1'b0, en: 1'b1, exp_pulse: 4'b0000};
    vecs[3] = '{ad: 1'b0, vf: 1'b1, as_n: 1'b0, en: 1'b1, exp_pulse: 4'b0000};
    vecs[4] = '{ad: 1'b1, vf: 1'b1, as_n: 1'b0, en: 1'b0, exp_pulse: 4'b0000};

    b1.Rx = 1'b0; b1.Rx_FlagDetect = 1'b0; b1.Rx_AbortDetect = 1'b0;
    b1.Rx_ValidFrame = 1'b0; b1.Rx_AbortSignal = 1'b0;
    b1.Tx = 1'b1; b1.Tx_ValidFrame = 1'b0; b1.Chk_En = 4'hF; b1.Clr = 1'b0;

    Rst = 1'b0;
    tick(); tick();
    Rst = 1'b1;
    check("reset pulse",  32'(b1.Err_Pulse), 32'h0);
    check("reset sticky", 32'(b1.Err_Sticky), 32'h0);
    check("reset cnt",    32'(b1.Err_Cnt), 32'h0);
    check("reset fval",   32'(b1.First_Err_Valid), 32'h0);
    check("reset fid",    32'(b1.First_Err_Id), 32'h0);

    // Scenario 1: flag detect on time, then withheld
    b1.Rx = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    send_rx(8'b0111_1110);
    tick();
    b1.Rx_FlagDetect = 1'b1;
    tick();
    b1.Rx_FlagDetect = 1'b0;
    check("flag on time pulse", 32'(b1.Err_Pulse), 32'h0);
    tick(); tick();
    send_rx(8'b0111_1110);
    tick(); tick();
    check("flag miss pulse", 32'(b1.Err_Pulse), 32'h1);
    check("flag miss cnt",   32'(b1.Err_Cnt), 32'h1);
    check("flag miss fid",   32'(b1.First_Err_Id), 32'h0);
    check("flag miss fval",  32'(b1.First_Err_Valid), 32'h1);
    tick();
    check("flag pulse one cycle", 32'(b1.Err_Pulse), 32'h0);
    check("flag sticky held",     32'(b1.Err_Sticky), 32'h1);
    exp_cnt = 1;

    // Scenario 2: abort detect rising on time, then one cycle late
    send_rx(8'b0111_1111);
    tick();
    b1.Rx_AbortDetect = 1'b1;
    tick();
    b1.Rx_AbortDetect = 1'b0;
    check("abort on time pulse", 32'(b1.Err_Pulse), 32'h0);
    tick(); tick();
    send_rx(8'b0111_1111);
    tick(); tick();
    b1.Rx_AbortDetect = 1'b1;
    check("abort late pulse", 32'(b1.Err_Pulse), 32'h2);
    tick();
    b1.Rx_AbortDetect = 1'b0;
    check("abort late pulse gone", 32'(b1.Err_Pulse), 32'h0);
    exp_cnt = 2;
    check("abort late cnt", 32'(b1.Err_Cnt), 32'(exp_cnt));
    check("first err kept", 32'(b1.First_Err_Id), 32'h0);
    tick();

    // Scenario 3: abort-signal check vectors including masking
    for (int v = 0; v < 5; v++) begin
      b1.Rx_AbortDetect = vecs[v].ad;
      b1.Rx_ValidFrame  = vecs[v].vf;
      tick();
      b1.Rx_AbortDetect = 1'b0;
      b1.Rx_ValidFrame  = 1'b0;
      b1.Rx_AbortSignal = vecs[v].as_n;
      b1.Chk_En[2]      = vecs[v].en;
      tick();
      b1.Rx_AbortSignal = 1'b0;
      b1.Chk_En         = 4'hF;
      check($sformatf("abortsig vec%0d pulse", v), 32'(b1.Err_Pulse), 32'(vecs[v].exp_pulse));
      if (vecs[v].exp_pulse != 4'b0000) exp_cnt++;
      check($sformatf("abortsig vec%0d cnt", v), 32'(b1.Err_Cnt), 32'(exp_cnt));
      tick();
    end

    // Scenario 4: idle check boundary (9th cycle not due, 10th due)
    b1.Tx_ValidFrame = 1'b1;
    tick();
    b1.Tx_ValidFrame = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    b1.Tx = 1'b0;
    tick();
    check("idle 9th not due", 32'(b1.Err_Pulse), 32'h0);
    tick();
    b1.Tx = 1'b1;
    check("idle 10th pulse", 32'(b1.Err_Pulse), 32'h8);
    check("idle sticky",     32'(b1.Err_Sticky), 32'hF);
    exp_cnt++;
    check("idle cnt", 32'(b1.Err_Cnt), 32'(exp_cnt));

    // Scenario 5a: simultaneous abort and idle failures after a clear
    b1.Clr = 1'b1;
    tick();
    b1.Clr = 1'b0;
    check("clr cnt",    32'(b1.Err_Cnt), 32'h0);
    check("clr sticky", 32'(b1.Err_Sticky), 32'h0);
    check("clr fval",   32'(b1.First_Err_Valid), 32'h0);
    send_rx(8'b0111_1111);
    tick();
    b1.Tx = 1'b0;
    tick();
    b1.Tx = 1'b1;
    check("dual pulse", 32'(b1.Err_Pulse), 32'hA);
    check("dual cnt",   32'(b1.Err_Cnt), 32'h2);
    check("dual fid",   32'(b1.First_Err_Id), 32'h1);
    check("dual fval",  32'(b1.First_Err_Valid), 32'h1);
    tick(); tick();

    // Scenario 5b: clear coinciding with a flag failure
    send_rx(8'b0111_1110);
    tick();
    b1.Clr = 1'b1;
    tick();
    b1.Clr = 1'b0;
    check("clr+fail sticky", 32'(b1.Err_Sticky), 32'h1);
    check("clr+fail cnt",    32'(b1.Err_Cnt), 32'h1);
    check("clr+fail fid",    32'(b1.First_Err_Id), 32'h0);
    check("clr+fail fval",   32'(b1.First_Err_Valid), 32'h1);
    check("clr+fail pulse",  32'(b1.Err_Pulse), 32'h1);

    // Scenario 6: counter saturation at CNT_W=2
    b1.Clr = 1'b1;
    tick();
    b1.Clr = 1'b0;
    b1.Tx = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    b1.Tx = 1'b1;
    check("five fails cnt16", 32'(b1.Err_Cnt), 32'h5);
    check("five fails cnt2",  32'(b2.Err_Cnt), 32'h3);
    tick();

    // Scenario 6: reset one cycle after a flag match discards the expectation
    send_rx(8'b0111_1110);
    Rst = 1'b0;
    tick();
    Rst = 1'b1;
    tick();
    check("rst pend pulse",  32'(b1.Err_Pulse), 32'h0);
    check("rst pend sticky", 32'(b1.Err_Sticky), 32'h0);
    check("rst pend cnt",    32'(b1.Err_Cnt), 32'h0);
    check("rst pend fval",   32'(b1.First_Err_Valid), 32'h0);
    check("rst pend fid",    32'(b1.First_Err_Id), 32'h0);
    check("rst pend cnt2",   32'(b2.Err_Cnt), 32'h0);
    tick();
    check("rst pend pulse later", 32'(b1.Err_Pulse), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
